// File: rtl/bridge_pkg.sv
// Shared types and helpers for slow_clk_sample_bridge and its edge synchroniser.
package bridge_pkg;

  typedef enum logic [0:0] {
    ST_PRIME = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  localparam int SYNC_MIN = 2;

  function automatic int level_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/slow_edge_sync.sv
// Synchronises an asynchronous slow clock into the fast domain and emits a
// one-cycle pulse on the selected edge (EDGE_RISING=1 rising, 0 falling).
module slow_edge_sync
  import bridge_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_RISING = 1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic async_i,
  output logic edge_o
);

  // Never build fewer flops than a safe synchroniser needs.
  localparam int N = (SYNC_STAGES < SYNC_MIN) ? SYNC_MIN : SYNC_STAGES;

  logic [N-1:0] sync_q;
  logic         hist_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[N-2:0], async_i};
      hist_q <= sync_q[N-1];
    end
  end

  generate
    if (EDGE_RISING != 0) begin : g_rise
      assign edge_o = sync_q[N-1] & ~hist_q;
    end else begin : g_fall
      assign edge_o = ~sync_q[N-1] & hist_q;
    end
  endgenerate

endmodule

// File: rtl/slow_clk_sample_bridge.sv
// Fast-clock FIFO bridge that presents one frame per slow_clk edge, with priming,
// underflow recovery and sticky status. Optional macro: BRIDGE_UNDERFLOW_CNT_EN.
module slow_clk_sample_bridge
  import bridge_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int CHANNELS    = 2,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_RISING = 1,
  parameter int PRIME_LEVEL = 2
) (
  input  logic                          inclk,
  input  logic                          reset,
  input  logic                          slow_clk,
  input  logic [CHANNELS*WIDTH-1:0]     in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [CHANNELS*WIDTH-1:0]     out_data,
  output logic                          out_strobe,
  output logic [level_w(DEPTH)-1:0]     level,
`ifdef BRIDGE_UNDERFLOW_CNT_EN
  output logic [15:0]                   underflow_cnt,
`endif
  output logic                          running,
  output logic                          overflow,
  output logic                          underflow,
  input  logic                          status_clr
);

  localparam int FRAME_W = CHANNELS * WIDTH;
  localparam int LEVEL_W = level_w(DEPTH);
  localparam int PTR_W   = $clog2(DEPTH);

  logic [FRAME_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]   wptr_q, rptr_q;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic [FRAME_W-1:0] out_q;
  logic               strobe_q;
  logic               ovf_q, ovf_d;
  logic               udf_q, udf_d;
  state_e             state_q, state_d;

  logic slow_edge;
  logic push, pop, uf_evt, of_evt;

  slow_edge_sync #(
    .SYNC_STAGES (SYNC_STAGES),
    .EDGE_RISING (EDGE_RISING)
  ) u_sync (
    .clk_i   (inclk),
    .rst_i   (reset),
    .async_i (slow_clk),
    .edge_o  (slow_edge)
  );

  // in_ready looks at the pre-pop level, so a full FIFO refuses even on a pop cycle.
  assign in_ready = (level_q != LEVEL_W'(DEPTH));
  assign push     = in_valid & in_ready;
  assign of_evt   = in_valid & ~in_ready;
  assign pop      = (state_q == ST_RUN) & slow_edge & (level_q != '0);
  assign uf_evt   = (state_q == ST_RUN) & slow_edge & (level_q == '0);

  always_comb begin
    level_d = level_q + LEVEL_W'(push) - LEVEL_W'(pop);
    state_d = state_q;
    case (state_q)
      ST_PRIME: if (level_q >= LEVEL_W'(PRIME_LEVEL)) state_d = ST_RUN;
      ST_RUN:   if (uf_evt) state_d = ST_PRIME;
      default:  state_d = ST_PRIME;
    endcase
    // A fresh event outranks a simultaneous clear.
    ovf_d = of_evt ? 1'b1 : (status_clr ? 1'b0 : ovf_q);
    udf_d = uf_evt ? 1'b1 : (status_clr ? 1'b0 : udf_q);
  end

  always_ff @(posedge inclk) begin
    if (push) mem_q[wptr_q] <= in_data;
  end

  always_ff @(posedge inclk) begin
    if (reset) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      level_q  <= '0;
      state_q  <= ST_PRIME;
      out_q    <= '0;
      strobe_q <= 1'b0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      if (push) wptr_q <= wptr_q + PTR_W'(1);
      if (pop) begin
        rptr_q <= rptr_q + PTR_W'(1);
        out_q  <= mem_q[rptr_q];
      end
      level_q  <= level_d;
      state_q  <= state_d;
      strobe_q <= pop;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

`ifdef BRIDGE_UNDERFLOW_CNT_EN
  logic [15:0] ucnt_q;

  always_ff @(posedge inclk) begin
    if (reset) begin
      ucnt_q <= '0;
    end else if (uf_evt) begin
      if (status_clr)             ucnt_q <= 16'd1;
      else if (ucnt_q != 16'hFFFF) ucnt_q <= ucnt_q + 16'd1;
    end else if (status_clr) begin
      ucnt_q <= '0;
    end
  end

  assign underflow_cnt = ucnt_q;
`endif

  assign out_data   = out_q;
  assign out_strobe = strobe_q;
  assign level      = level_q;
  assign running    = (state_q == ST_RUN);
  assign overflow   = ovf_q;
  assign underflow  = udf_q;

endmodule

// File: tb/tb_slow_clk_sample_bridge.sv
// Directed bench: a rising-edge bridge driven from a vector table plus
// hand-written drain/underflow sequences, and a falling-edge bridge with mid-stream reset.
module tb_slow_clk_sample_bridge;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // Rising-edge instance
  logic        rst, slow, valid, clr;
  logic [31:0] din;
  logic        rdy, stb, run, ovf, udf;
  logic [31:0] dout;
  logic [2:0]  lvl;
  // Falling-edge instance
  logic        f_rst, f_slow, f_valid, f_clr;
  logic [31:0] f_din;
  logic        f_rdy, f_stb, f_run, f_ovf, f_udf;
  logic [31:0] f_dout;
  logic [2:0]  f_lvl;
`ifdef BRIDGE_UNDERFLOW_CNT_EN
  logic [15:0] ucnt, f_ucnt;
`endif

  slow_clk_sample_bridge u_dut (
    .inclk(clk), .reset(rst), .slow_clk(slow), .in_data(din), .in_valid(valid),
    .in_ready(rdy), .out_data(dout), .out_strobe(stb), .level(lvl),
`ifdef BRIDGE_UNDERFLOW_CNT_EN
    .underflow_cnt(ucnt),
`endif
    .running(run), .overflow(ovf), .underflow(udf), .status_clr(clr)
  );

  slow_clk_sample_bridge #(.EDGE_RISING(0)) u_fall (
    .inclk(clk), .reset(f_rst), .slow_clk(f_slow), .in_data(f_din), .in_valid(f_valid),
    .in_ready(f_rdy), .out_data(f_dout), .out_strobe(f_stb), .level(f_lvl),
`ifdef BRIDGE_UNDERFLOW_CNT_EN
    .underflow_cnt(f_ucnt),
`endif
    .running(f_run), .overflow(f_ovf), .underflow(f_udf), .status_clr(f_clr)
  );

  typedef struct {
    logic        v;
    logic [31:0] d;
    logic        s;
    logic        c;
    logic [2:0]  lvl;
    logic        run;
    logic        stb;
    logic [31:0] out;
    logic        rdy;
    logic        ovf;
    logic        udf;
  } vec_t;

  vec_t vecs[$];
  int   total = 0;
  int   bad   = 0;

  localparam logic [31:0] FA = 32'hAAAA_0001, FB = 32'hBBBB_0002, FC = 32'hCCCC_0003,
                          FD = 32'hDDDD_0004, FE = 32'hEEEE_0005, FF = 32'h1111_0006,
                          FG = 32'h2222_0007, FH = 32'h8888_0008;

  task automatic add(input logic v, input logic [31:0] d, input logic s, input logic c,
                     input logic [2:0] l, input logic r, input logic sb, input logic [31:0] o,
                     input logic rd, input logic ov, input logic ud);
    vec_t x;
    x.v = v; x.d = d; x.s = s; x.c = c; x.lvl = l; x.run = r; x.stb = sb;
    x.out = o; x.rdy = rd; x.ovf = ov; x.udf = ud;
    vecs.push_back(x);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Full slow period ending in a rising edge; checks the cycle the update should land on.
  task automatic rise_and_check(input string nm, input logic exp_stb, input logic [31:0] exp_out,
                                input logic clr_on_edge);
    slow = 1'b0;
    repeat (3) tick();
    slow = 1'b1;
    tick();
    chk({nm, " no early strobe"}, {31'd0, stb}, 32'd0);
    tick();
    clr = clr_on_edge;
    tick();
    clr = 1'b0;
    chk({nm, " strobe"}, {31'd0, stb}, {31'd0, exp_stb});
    chk({nm, " out"}, dout, exp_out);
  endtask

  initial begin
    rst = 1'b1; slow = 1'b0; valid = 1'b0; clr = 1'b0; din = '0;
    f_rst = 1'b1; f_slow = 1'b0; f_valid = 1'b0; f_clr = 1'b0; f_din = '0;

    //   v  d   s  c  lvl run stb out rdy ovf udf
    add(1, FA, 0, 0, 1, 0, 0, 0,  1, 0, 0);
    add(1, FB, 0, 0, 2, 0, 0, 0,  1, 0, 0);
    add(0, 0,  0, 0, 2, 1, 0, 0,  1, 0, 0);
    add(0, 0,  1, 0, 2, 1, 0, 0,  1, 0, 0);
    add(0, 0,  1, 0, 2, 1, 0, 0,  1, 0, 0);
    add(0, 0,  1, 0, 1, 1, 1, FA, 1, 0, 0);
    add(0, 0,  1, 0, 1, 1, 0, FA, 1, 0, 0);
    add(0, 0,  0, 0, 1, 1, 0, FA, 1, 0, 0);
    add(0, 0,  0, 0, 1, 1, 0, FA, 1, 0, 0);
    add(0, 0,  0, 0, 1, 1, 0, FA, 1, 0, 0);
    add(0, 0,  1, 0, 1, 1, 0, FA, 1, 0, 0);
    add(0, 0,  1, 0, 1, 1, 0, FA, 1, 0, 0);
    add(0, 0,  1, 0, 0, 1, 1, FB, 1, 0, 0);
    add(0, 0,  0, 0, 0, 1, 0, FB, 1, 0, 0);
    add(0, 0,  0, 0, 0, 1, 0, FB, 1, 0, 0);
    add(0, 0,  0, 0, 0, 1, 0, FB, 1, 0, 0);
    add(0, 0,  1, 0, 0, 1, 0, FB, 1, 0, 0);
    add(0, 0,  1, 0, 0, 1, 0, FB, 1, 0, 0);
    add(0, 0,  1, 0, 0, 0, 0, FB, 1, 0, 1);   // underflow, back to PRIME
    add(1, FC, 1, 0, 1, 0, 0, FB, 1, 0, 1);
    add(1, FD, 1, 0, 2, 0, 0, FB, 1, 0, 1);
    add(0, 0,  0, 0, 2, 1, 0, FB, 1, 0, 1);
    add(0, 0,  0, 0, 2, 1, 0, FB, 1, 0, 1);
    add(0, 0,  0, 0, 2, 1, 0, FB, 1, 0, 1);
    add(0, 0,  1, 0, 2, 1, 0, FB, 1, 0, 1);
    add(0, 0,  1, 0, 2, 1, 0, FB, 1, 0, 1);
    add(0, 0,  1, 0, 1, 1, 1, FC, 1, 0, 1);
    add(0, 0,  1, 1, 1, 1, 0, FC, 1, 0, 0);   // status_clr alone
    add(1, FE, 1, 0, 2, 1, 0, FC, 1, 0, 0);
    add(1, FF, 1, 0, 3, 1, 0, FC, 1, 0, 0);
    add(1, FG, 1, 0, 4, 1, 0, FC, 0, 0, 0);
    add(1, FH, 1, 0, 4, 1, 0, FC, 0, 1, 0);   // push while full
    add(1, FH, 0, 0, 4, 1, 0, FC, 0, 1, 0);
    add(1, FH, 0, 0, 4, 1, 0, FC, 0, 1, 0);
    add(1, FH, 0, 0, 4, 1, 0, FC, 0, 1, 0);
    add(1, FH, 1, 0, 4, 1, 0, FC, 0, 1, 0);
    add(1, FH, 1, 0, 4, 1, 0, FC, 0, 1, 0);
    add(1, FH, 1, 0, 3, 1, 1, FD, 1, 1, 0);
    add(1, FH, 1, 0, 4, 1, 0, FD, 0, 1, 0);
    add(0, 0,  1, 0, 4, 1, 0, FD, 0, 1, 0);

    tick(); tick();
    chk("reset level", {29'd0, lvl}, 32'd0);
    chk("reset out", dout, 32'd0);
    chk("reset flags", {27'd0, stb, run, ovf, udf, rdy}, 32'd1);
    rst = 1'b0; f_rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      valid = vecs[i].v; din = vecs[i].d; slow = vecs[i].s; clr = vecs[i].c;
      tick();
      chk($sformatf("row%0d level", i), {29'd0, lvl}, {29'd0, vecs[i].lvl});
      chk($sformatf("row%0d running", i), {31'd0, run}, {31'd0, vecs[i].run});
      chk($sformatf("row%0d strobe", i), {31'd0, stb}, {31'd0, vecs[i].stb});
      chk($sformatf("row%0d out", i), dout, vecs[i].out);
      chk($sformatf("row%0d ready", i), {31'd0, rdy}, {31'd0, vecs[i].rdy});
      chk($sformatf("row%0d overflow", i), {31'd0, ovf}, {31'd0, vecs[i].ovf});
      chk($sformatf("row%0d underflow", i), {31'd0, udf}, {31'd0, vecs[i].udf});
    end
    valid = 1'b0; clr = 1'b0;

    // Drain E, F, G, H, then underflow with a simultaneous clear.
    rise_and_check("drain E", 1'b1, FE, 1'b0);
    rise_and_check("drain F", 1'b1, FF, 1'b0);
    rise_and_check("drain G", 1'b1, FG, 1'b0);
    rise_and_check("drain H", 1'b1, FH, 1'b0);
    chk("drained level", {29'd0, lvl}, 32'd0);
    rise_and_check("uf+clr", 1'b0, FH, 1'b1);
    chk("uf+clr underflow kept", {31'd0, udf}, 32'd1);
    chk("uf+clr not running", {31'd0, run}, 32'd0);
`ifdef BRIDGE_UNDERFLOW_CNT_EN
    chk("uf+clr count", {16'd0, ucnt}, 32'd1);
`endif
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr alone underflow", {31'd0, udf}, 32'd0);
    chk("clr alone overflow", {31'd0, ovf}, 32'd0);
`ifdef BRIDGE_UNDERFLOW_CNT_EN
    chk("clr alone count", {16'd0, ucnt}, 32'd0);
`endif

    // Falling-edge instance: prime, pop one, then reset mid-stream at level 3.
    f_valid = 1'b1;
    f_din = 32'h0101_00A1; tick();
    f_din = 32'h0202_00A2; tick();
    f_din = 32'h0303_00A3; tick();
    f_din = 32'h0404_00A4; tick();
    f_valid = 1'b0;
    tick();
    chk("fall primed running", {31'd0, f_run}, 32'd1);
    chk("fall primed level", {29'd0, f_lvl}, 32'd4);
    f_slow = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("fall rise%0d no strobe", k), {31'd0, f_stb}, 32'd0);
    end
    f_slow = 1'b0;
    tick(); tick();
    chk("fall early strobe", {31'd0, f_stb}, 32'd0);
    tick();
    chk("fall pop strobe", {31'd0, f_stb}, 32'd1);
    chk("fall pop out", f_dout, 32'h0101_00A1);
    chk("fall pop level", {29'd0, f_lvl}, 32'd3);
    f_rst = 1'b1;
    tick();
    f_rst = 1'b0;
    chk("fall reset level", {29'd0, f_lvl}, 32'd0);
    chk("fall reset out", f_dout, 32'd0);
    chk("fall reset running", {31'd0, f_run}, 32'd0);
    f_valid = 1'b1;
    f_din = 32'h0505_00B1; tick();
    f_din = 32'h0606_00B2; tick();
    f_valid = 1'b0;
    tick();
    chk("fall reprimed", {31'd0, f_run}, 32'd1);
    f_slow = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("fall rise2_%0d no strobe", k), {31'd0, f_stb}, 32'd0);
    end
    f_slow = 1'b0;
    tick(); tick();
    tick();
    chk("fall repop strobe", {31'd0, f_stb}, 32'd1);
    chk("fall repop out", f_dout, 32'h0505_00B1);
    chk("fall repop level", {29'd0, f_lvl}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
